// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that packs incoming bytes into 24-bit GRB words and streams them
// into the LED memory write port, one chip-select assertion per frame.
module spi_frame_loader #(
  parameter int LED_COUNT  = 256,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock_12mhz,
  input  logic                  reset_n,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  perform_write,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [23:0]           write_data,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] words_received,
  output logic                  overflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  // One spare bit so the address can saturate at LED_COUNT even when it is a power of two
  localparam logic [ADDR_WIDTH:0] LED_MAX = (ADDR_WIDTH+1)'(LED_COUNT);

  logic [2:0]          sck_sync;
  logic [1:0]          mosi_sync;
  logic [1:0]          cs_sync;
  logic                sck_rise;
  logic                mosi_s;
  logic                cs_n_s;
  logic [1:0]          state;
  logic [4:0]          bit_cnt;
  logic [23:0]         shift;
  logic [ADDR_WIDTH:0] word_addr;

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= 2'b11;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign mosi_s   = mosi_sync[1];
  assign cs_n_s   = cs_sync[1];

  // Outputs are registered: the write strobe and frame_done appear the cycle after
  // COMMIT/FINISH, four clock edges after the SCK / CS pin edge.
  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      word_addr      <= '0;
      perform_write  <= 1'b0;
      write_address  <= '0;
      write_data     <= '0;
      frame_done     <= 1'b0;
      words_received <= '0;
      overflow       <= 1'b0;
    end else begin
      perform_write <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_n_s) begin
            state          <= RECEIVE;
            bit_cnt        <= '0;
            word_addr      <= '0;
            words_received <= '0;
            overflow       <= 1'b0;
          end
        end
        RECEIVE: begin
          // A completing bit wins over CS release so the last word is still committed
          if (sck_rise) begin
            shift <= {shift[22:0], mosi_s};
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              state   <= COMMIT;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (cs_n_s) begin
            state <= FINISH;
          end
        end
        COMMIT: begin
          if (word_addr < LED_MAX) begin
            perform_write <= 1'b1;
            write_data    <= shift;
            write_address <= word_addr[ADDR_WIDTH-1:0];
            word_addr     <= word_addr + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
          if (sck_rise) begin
            shift   <= {shift[22:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
          end
          state <= RECEIVE;
        end
        default: begin
          // word_addr never exceeds LED_COUNT, so it already is the clamped count
          frame_done     <= 1'b1;
          words_received <= word_addr[ADDR_WIDTH-1:0];
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
